// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared RV32I decode definitions for the ID/EX issue path.
//   DATA_SIZE      : datapath width
//   CTRL_W         : ALU control code width
//   alu_op_t       : ALU operation codes exactly as the ALU consumes them
//   OPC_* / F3_* / F7_* : opcode, funct3 and funct7 encodings
//   issue_fields_t : every field the issue stage registers at the ID/EX boundary
package riscv_pkg;

  localparam int DATA_SIZE = 32;
  localparam int CTRL_W    = 4;

  typedef enum logic [CTRL_W-1:0] {
    ALU_LUI  = 4'd0,
    ALU_ADDR = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_XOR  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_AND  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_SUB  = 4'd9,
    ALU_SLT  = 4'd10,
    ALU_SLTU = 4'd11
  } alu_op_t;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  // Arithmetic funct3 values (shared by OP and OP-IMM)
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // Memory access funct3 values
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [DATA_SIZE-1:0] alu_a;
    logic [DATA_SIZE-1:0] alu_b;
    alu_op_t              alu_control;
    logic [4:0]           rd_addr;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic [2:0]           mem_size;
    logic [DATA_SIZE-1:0] store_data;
    logic                 illegal;
  } issue_fields_t;

  // Sign-extend a 12-bit immediate to the datapath width
  function automatic logic [DATA_SIZE-1:0] sext12(input logic [11:0] imm);
    return {{(DATA_SIZE-12){imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode
// Purely combinational RV32I decoder for the ALU issue path.
//   instr    (in)  : fetched instruction
//   rs1_data (in)  : rs1 register value
//   rs2_data (in)  : rs2 register value
//   fields   (out) : ALU code, A/B operands and EX/MEM/WB side-band fields
module alu_ctrl_decode
  import riscv_pkg::*;
(
  input  logic [31:0]          instr,
  input  logic [DATA_SIZE-1:0] rs1_data,
  input  logic [DATA_SIZE-1:0] rs2_data,
  output issue_fields_t        fields
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic [DATA_SIZE-1:0] i_imm;
  logic [DATA_SIZE-1:0] s_imm;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign i_imm  = sext12(instr[31:20]);
  assign s_imm  = sext12({instr[31:25], instr[11:7]});

  // Decode opcode/funct3/funct7 into the ALU code and operands. Any
  // encoding not recognised falls through with legal=0 and is then
  // rewritten into the canonical illegal beat below, so the ALU sees a
  // harmless ADD of zeros and nothing downstream gets enabled.
  always_comb begin
    logic                 legal;
    logic                 rw;
    alu_op_t              op;
    logic [DATA_SIZE-1:0] a;
    logic [DATA_SIZE-1:0] b;

    legal  = 1'b0;
    rw     = 1'b0;
    op     = ALU_ADD;
    a      = '0;
    b      = '0;
    fields = '0;
    fields.alu_control = ALU_ADD;
    fields.rd_addr     = rd;

    case (opcode)
      OPC_LUI: begin
        legal = 1'b1;
        op    = ALU_LUI;
        b     = {12'b0, instr[31:12]};
        rw    = 1'b1;
      end
      OPC_LOAD: begin
        legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                (funct3 == F3_BU) || (funct3 == F3_HU);
        op    = ALU_ADDR;
        a     = rs1_data;
        b     = i_imm;
        rw    = 1'b1;
        fields.mem_read = 1'b1;
        fields.mem_size = funct3;
      end
      OPC_STORE: begin
        legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        op    = ALU_ADDR;
        a     = rs1_data;
        b     = s_imm;
        fields.mem_write  = 1'b1;
        fields.mem_size   = funct3;
        fields.store_data = rs2_data;
      end
      OPC_OPIMM: begin
        a     = rs1_data;
        b     = i_imm;
        rw    = 1'b1;
        legal = 1'b1;
        case (funct3)
          F3_ADD_SUB: op = ALU_ADD;
          F3_SLT:     op = ALU_SLT;
          F3_SLTU:    op = ALU_SLTU;
          F3_XOR:     op = ALU_XOR;
          F3_OR:      op = ALU_OR;
          F3_AND:     op = ALU_AND;
          F3_SLL: begin
            op    = ALU_SLL;
            b     = {27'b0, instr[24:20]};
            legal = (funct7 == F7_BASE);
          end
          default: begin
            op    = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            b     = {27'b0, instr[24:20]};
            legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          end
        endcase
      end
      OPC_OP: begin
        a  = rs1_data;
        b  = rs2_data;
        rw = 1'b1;
        // Only ADD/SUB and SRL/SRA accept the alternate funct7
        legal = (funct7 == F7_BASE) ||
                ((funct7 == F7_ALT) &&
                 ((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA)));
        case (funct3)
          F3_ADD_SUB: op = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
          F3_SLT:     op = ALU_SLT;
          F3_SLTU:    op = ALU_SLTU;
          F3_XOR:     op = ALU_XOR;
          F3_OR:      op = ALU_OR;
          F3_AND:     op = ALU_AND;
          F3_SLL: begin
            op = ALU_SLL;
            b  = {27'b0, rs2_data[4:0]};
          end
          default: begin
            op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            b  = {27'b0, rs2_data[4:0]};
          end
        endcase
      end
      default: legal = 1'b0;
    endcase

    if (legal) begin
      fields.alu_control = op;
      fields.alu_a       = a;
      fields.alu_b       = b;
      fields.reg_write   = rw && (rd != 5'd0);
    end else begin
      fields.alu_control = ALU_ADD;
      fields.alu_a       = '0;
      fields.alu_b       = '0;
      fields.reg_write   = 1'b0;
      fields.mem_read    = 1'b0;
      fields.mem_write   = 1'b0;
      fields.mem_size    = '0;
      fields.store_data  = '0;
      fields.illegal     = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// One-entry valid/ready pipeline register at the ID/EX boundary that
// issues decoded RV32I beats to the ALU.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : upstream handshake
//   instr, rs1/rs2_data : instruction and its register operands
//   flush               : drop the held beat and any beat offered this cycle
//   out_valid/out_ready : downstream (EX) handshake
//   alu_a/alu_b/alu_control, rd_addr, reg_write, mem_read, mem_write,
//   mem_size, store_data, illegal : registered issue fields
module alu_issue_stage
  import riscv_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic [DATA_SIZE-1:0] rs1_data,
  input  logic [DATA_SIZE-1:0] rs2_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] alu_a,
  output logic [DATA_SIZE-1:0] alu_b,
  output logic [CTRL_W-1:0]    alu_control,
  output logic [4:0]           rd_addr,
  output logic                 reg_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [2:0]           mem_size,
  output logic [DATA_SIZE-1:0] store_data,
  output logic                 illegal
);

  issue_fields_t decoded;
  issue_fields_t held;

  alu_ctrl_decode u_decode (
    .instr    (instr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .fields   (decoded)
  );

  // The slot is free when empty or when its beat leaves this cycle
  assign in_ready = !out_valid || out_ready;

  // Reset wins over flush, flush wins over accept. The held data is only
  // rewritten on a real accept so a stalled beat stays bit-stable; a
  // flush clears just the valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      held      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        held <= decoded;
      end
    end
  end

  assign alu_a       = held.alu_a;
  assign alu_b       = held.alu_b;
  assign alu_control = held.alu_control;
  assign rd_addr     = held.rd_addr;
  assign reg_write   = held.reg_write;
  assign mem_read    = held.mem_read;
  assign mem_write   = held.mem_write;
  assign mem_size    = held.mem_size;
  assign store_data  = held.store_data;
  assign illegal     = held.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage
// Scoreboard bench for alu_issue_stage: directed instructions push their
// hand-computed expected beat into a queue, and a monitor pops and compares
// every beat that EX accepts (out_valid && out_ready).
module tb_alu_issue_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_control;
  logic [4:0]  rd_addr;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_size;
  logic [31:0] store_data;
  logic        illegal;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [11:0] side;
    logic [31:0] sdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  alu_issue_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .rd_addr     (rd_addr),
    .reg_write   (reg_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_size    (mem_size),
    .store_data  (store_data),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Side-band fields packed as {rd, reg_write, mem_read, mem_write, mem_size, illegal}
  function automatic logic [11:0] sideNow();
    return {rd_addr, reg_write, mem_read, mem_write, mem_size, illegal};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual === required) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, required);
  endtask

  task automatic applyStimulus(input logic [31:0] i, input logic [31:0] r1,
                               input logic [31:0] r2);
    in_valid = 1'b1;
    instr    = i;
    rs1_data = r1;
    rs2_data = r2;
  endtask

  task automatic expectBeat(input string n, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] c, input logic [4:0] rd, input logic rw,
                            input logic mr, input logic mw, input logic [2:0] ms,
                            input logic [31:0] sd, input logic ill);
    exp_t e;
    e.name  = n;
    e.a     = a;
    e.b     = b;
    e.ctrl  = c;
    e.side  = {rd, rw, mr, mw, ms, ill};
    e.sdata = sd;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every beat EX takes must match the oldest expected beat
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        checkOutput("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checkOutput({e.name, ".alu_a"}, alu_a, e.a);
          checkOutput({e.name, ".alu_b"}, alu_b, e.b);
          checkOutput({e.name, ".alu_control"}, 32'(alu_control), 32'(e.ctrl));
          checkOutput({e.name, ".side"}, 32'(sideNow()), 32'(e.side));
          checkOutput({e.name, ".store_data"}, store_data, e.sdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    instr = '0; rs1_data = '0; rs2_data = '0;
    step();
    step();
    checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset.in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset.alu_a", alu_a, 32'd0);
    checkOutput("reset.alu_b", alu_b, 32'd0);
    checkOutput("reset.alu_control", 32'(alu_control), 32'd0);
    checkOutput("reset.side", 32'(sideNow()), 32'd0);
    checkOutput("reset.store_data", store_data, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;

    // Back-to-back stream with EX always ready
    applyStimulus(32'hFFF10093, 32'd5, 32'd0);
    expectBeat("addi", 32'd5, 32'hFFFFFFFF, 4'd2, 5'd1, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
    step();
    checkOutput("addi_latency.out_valid", 32'(out_valid), 32'd1);

    applyStimulus(32'h123452B7, 32'hAAAA5555, 32'h0);
    expectBeat("lui", 32'd0, 32'h00012345, 4'd0, 5'd5, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
    step();
    applyStimulus(32'h40325193, 32'h80000000, 32'h0);
    expectBeat("srai", 32'h80000000, 32'd3, 4'd8, 5'd3, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
    step();
    applyStimulus(32'h4083D333, 32'h12345678, 32'hFFFFFF23);
    expectBeat("sra", 32'h12345678, 32'd3, 4'd8, 5'd6, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
    step();
    applyStimulus(32'h00208033, 32'd7, 32'd9);
    expectBeat("add_x0", 32'd7, 32'd9, 4'd2, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
    step();
    applyStimulus(32'h0000007F, 32'h11111111, 32'h22222222);
    expectBeat("illegal_opc", 32'd0, 32'd0, 4'd2, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
    step();
    applyStimulus(32'h40C58533, 32'd100, 32'd30);
    expectBeat("sub", 32'd100, 32'd30, 4'd9, 5'd10, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
    step();
    applyStimulus(32'hFFC12483, 32'h00001000, 32'h0);
    expectBeat("lw", 32'h00001000, 32'hFFFFFFFC, 4'd1, 5'd9, 1'b1, 1'b1, 1'b0, 3'd2, 32'd0, 1'b0);
    step();
    applyStimulus(32'h0050A423, 32'h00002000, 32'hDEADBEEF);
    expectBeat("sw", 32'h00002000, 32'd8, 4'd1, 5'd8, 1'b0, 1'b0, 1'b1, 3'd2, 32'hDEADBEEF, 1'b0);
    step();
    applyStimulus(32'h022080B3, 32'd3, 32'd4);
    expectBeat("illegal_f7", 32'd0, 32'd0, 4'd2, 5'd1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    checkOutput("stream_idle.out_valid", 32'(out_valid), 32'd0);

    // Backpressure: first beat held for three cycles while a second waits
    out_ready = 1'b0;
    applyStimulus(32'h00F2C213, 32'h000000F0, 32'h0);
    expectBeat("xori_held", 32'h000000F0, 32'h0000000F, 4'd3, 5'd4, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
    step();
    applyStimulus(32'hFF046393, 32'd1, 32'h0);
    for (int c = 0; c < 3; c++) begin
      checkOutput("stall.in_ready", 32'(in_ready), 32'd0);
      checkOutput("stall.alu_a", alu_a, 32'h000000F0);
      checkOutput("stall.alu_control", 32'(alu_control), 32'd3);
      checkOutput("stall.side", 32'(sideNow()), 32'({5'd4, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0}));
      step();
    end
    out_ready = 1'b1;
    expectBeat("ori_after_stall", 32'd1, 32'hFFFFFFF0, 4'd4, 5'd7, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
    step();
    checkOutput("bp_second.out_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_second.alu_control", 32'(alu_control), 32'd4);
    in_valid = 1'b0;
    step();

    // Flush while a beat is held: both held and offered beats vanish
    out_ready = 1'b0;
    applyStimulus(32'h01F00F93, 32'd0, 32'd0);
    step();
    flush = 1'b1;
    applyStimulus(32'h00F00F93, 32'd0, 32'd0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_held.out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    step();
    checkOutput("flush_held_idle.out_valid", 32'(out_valid), 32'd0);

    // Flush while empty: the offered beat is dropped although in_ready=1
    applyStimulus(32'h00100F93, 32'd0, 32'd0);
    flush = 1'b1;
    checkOutput("flush_empty.in_ready", 32'(in_ready), 32'd1);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_empty.out_valid", 32'(out_valid), 32'd0);

    // Reset during a stall drops the held beat
    out_ready = 1'b0;
    applyStimulus(32'h01F00F93, 32'd0, 32'd0);
    step();
    in_valid = 1'b0;
    checkOutput("pre_rst_stall.out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    checkOutput("rst_stall.out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_stall.alu_b", alu_b, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;

    // Normal operation resumes after reset
    applyStimulus(32'h0011B113, 32'd0, 32'd0);
    expectBeat("sltiu_post_rst", 32'd0, 32'd1, 4'd11, 5'd2, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
    step();
    in_valid = 1'b0;

    for (int w = 0; w < 50 && sb.size() > 0; w++) step();
    checkOutput("drain.sb_size", 32'(sb.size()), 32'd0);
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
